// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port plus the decoder-facing handshake.
// The master side is the fetch stage; the slave side is memory and decoder.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    input  instr_ready,
    output instr_valid,
    output instr,
    output instr_pc,
    output fetch_fault,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    output instr_ready,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  fetch_fault,
    input  fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory and holds one fetched entry for the decoder behind valid/ready.
// Misaligned or out-of-range PCs produce a sticky fault entry; the stage then
// stops fetching until a redirect (or reset) supplies a new PC.
module instr_fetch #(
  parameter logic [31:0] ResetPc   = 32'h0000_0000,
  parameter int unsigned ImemBytes = 4096
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  // Highest PC whose full word still lies inside the memory.
  localparam logic [31:0] PcMax = ImemBytes - 32'd4;

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic handshake;
  logic load_en;
  logic bad_pc;

  assign handshake = valid_q && bus.instr_ready;
  assign load_en   = !valid_q || bus.instr_ready;
  assign bad_pc    = (pc_q[1:0] != 2'b00) || (pc_q > PcMax);

  // Next-state: redirect beats capture; FAULT only drains its entry.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    // Handshakes count even when a redirect flushes the same cycle.
    count_d    = count_q + {31'd0, handshake};

    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_en) begin
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            if (bad_pc) begin
              // PC is frozen so the faulting address stays visible.
              instr_d = 32'd0;
              fault_d = 1'b1;
              state_d = StFault;
            end else begin
              instr_d = bus.imem_rdata;
              fault_d = 1'b0;
              pc_d    = pc_q + 32'd4;
            end
          end
        end
        StFault: begin
          if (handshake) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= ResetPc;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      fault_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: straight-line fetch, backpressure, redirect,
// misaligned and out-of-range faults, and reset during a stall.
module tb_instr_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_fetch_if bus ();

  instr_fetch #(
    .ResetPc   (32'h0000_0000),
    .ImemBytes (4096)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 4 KiB instruction memory; reads beyond it return a marker word.
  logic [31:0] mem [1024];
  assign bus.imem_rdata = (bus.imem_addr < 32'h0000_1000) ? mem[bus.imem_addr[11:2]]
                                                           : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed state: {valid, fault, instr_pc, instr, count, imem_addr}.
  // When full=0 the entry fields are masked since they are meaningless.
  function automatic logic [129:0] snap(input bit full);
    logic [129:0] s;
    s = {bus.instr_valid, bus.fetch_fault, bus.instr_pc, bus.instr,
         bus.fetch_count, bus.imem_addr};
    if (!full) s[128:64] = '0;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [129:0] exp;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 32'h0};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL reset: got %h want %h", snap(1), exp);
    end
    rst = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [129:0] exp;
    bus.instr_ready = 1'b1;
    tick();
    exp = {1'b1, 1'b0, 32'h0, 32'h11, 32'd0, 32'h4};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL first_fetch: got %h want %h", snap(1), exp);
    end
    tick();
    exp = {1'b1, 1'b0, 32'h4, 32'h22, 32'd1, 32'h8};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL second_fetch: got %h want %h", snap(1), exp);
    end
  endtask

  task automatic test_backpressure();
    logic [129:0] exp;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {1'b1, 1'b0, 32'h4, 32'h22, 32'd1, 32'h8};
      checks++;
      if (snap(1) !== exp) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, snap(1), exp);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    exp = {1'b1, 1'b0, 32'h8, 32'h33, 32'd2, 32'hC};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", snap(1), exp);
    end
  endtask

  task automatic test_redirect();
    logic [129:0] exp;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd3, 32'h40};
    checks++;
    if (snap(0) !== exp) begin
      errors++;
      $display("FAIL redirect_bubble: got %h want %h", snap(0), exp);
    end
    tick();
    exp = {1'b1, 1'b0, 32'h40, 32'hA000_0010, 32'd3, 32'h44};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL redirect_target: got %h want %h", snap(1), exp);
    end
  endtask

  task automatic test_misaligned();
    logic [129:0] exp;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h42;
    tick();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd4, 32'h42};
    checks++;
    if (snap(0) !== exp) begin
      errors++;
      $display("FAIL misalign_bubble: got %h want %h", snap(0), exp);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = {1'b1, 1'b1, 32'h42, 32'h0, 32'd4, 32'h42};
      checks++;
      if (snap(1) !== exp) begin
        errors++;
        $display("FAIL misalign_entry[%0d]: got %h want %h", i, snap(1), exp);
      end
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 32'h42};
      checks++;
      if (snap(0) !== exp) begin
        errors++;
        $display("FAIL fault_idle[%0d]: got %h want %h", i, snap(0), exp);
      end
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect = 1'b0;
    tick();
    exp = {1'b1, 1'b0, 32'h0, 32'h11, 32'd5, 32'h4};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL fault_resume: got %h want %h", snap(1), exp);
    end
  endtask

  task automatic test_out_of_range();
    logic [129:0] exp;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFC;
    tick();
    bus.redirect = 1'b0;
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd6, 32'hFFC};
    checks++;
    if (snap(0) !== exp) begin
      errors++;
      $display("FAIL range_bubble: got %h want %h", snap(0), exp);
    end
    tick();
    exp = {1'b1, 1'b0, 32'hFFC, 32'hA000_03FF, 32'd6, 32'h1000};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL last_word: got %h want %h", snap(1), exp);
    end
    tick();
    exp = {1'b1, 1'b1, 32'h1000, 32'h0, 32'd7, 32'h1000};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL range_fault: got %h want %h", snap(1), exp);
    end
    tick();
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd8, 32'h1000};
    checks++;
    if (snap(0) !== exp) begin
      errors++;
      $display("FAIL range_consume: got %h want %h", snap(0), exp);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [129:0] exp;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h8;
    tick();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    exp = {1'b1, 1'b0, 32'h8, 32'h33, 32'd8, 32'hC};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL pre_reset_hold: got %h want %h", snap(1), exp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 32'h0};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", snap(1), exp);
    end
    tick();
    exp = {1'b1, 1'b0, 32'h0, 32'h11, 32'd0, 32'h4};
    checks++;
    if (snap(1) !== exp) begin
      errors++;
      $display("FAIL refetch: got %h want %h", snap(1), exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_out_of_range();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the instruction memory. Holds the program counter and drives it as the byte address into the combinational instruction memory. Registers the returned word together with its PC into a single-entry fetch register, which it offers to the decoder through a valid/ready handshake. Supports branch/jump redirection with flush and raises a sticky fetch fault on misaligned or out-of-range PCs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 4096, instruction memory size in bytes. A PC is in range when pc <= IMEM_BYTES-4.

- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- imem_addr_o  out  32  byte address to instruction memory; always equals pc_q.
- imem_rdata_i  in  32  instruction word from memory, combinational from imem_addr_o in the same cycle.
- redirect_i  in  1  branch/jump taken; load a new PC and flush.
- redirect_pc_i  in  32  target byte address, sampled when redirect_i=1.
- instr_ready_i  in  1  decoder can accept instr_o this cycle.
- instr_valid_o  out  1  fetch register holds a valid entry.
- instr_o  out  32  fetched instruction.
- instr_pc_o  out  32  byte PC of instr_o.
- fetch_fault_o  out  1  qualified by instr_valid_o; entry came from a misaligned or out-of-range PC.
- fetch_count_o  out  32  count of completed handshakes (valid && ready).

## Operation
- State machine: RUN, FAULT. Reset state is RUN.
- Definitions:
  - load_en = !instr_valid_o || instr_ready_i
  - bad_pc = (pc_q[1:0] != 0) || (pc_q > IMEM_BYTES-4)
- Priority on each edge: rst_i > redirect_i > capture.
- Reset values: pc_q = RESET_PC, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, fetch_fault_o = 0, fetch_count_o = 0, state = RUN.
- Redirect (redirect_i=1, any state):
  - pc_q <= redirect_pc_i; instr_valid_o <= 0; fetch_fault_o <= 0; state <= RUN.
  - No capture happens in that cycle.
  - A handshake completing in the same cycle still counts.
- Capture (RUN, no redirect, load_en=1, bad_pc=0):
  - instr_o <= imem_rdata_i; instr_pc_o <= pc_q; instr_valid_o <= 1; fetch_fault_o <= 0; pc_q <= pc_q + 4 (modulo 2^32).
- Fault capture (RUN, no redirect, load_en=1, bad_pc=1):
  - instr_o <= 0; instr_pc_o <= pc_q; instr_valid_o <= 1; fetch_fault_o <= 1; pc_q holds; state <= FAULT.
- Stall (load_en=0): pc_q and all outputs hold.
- FAULT state:
  - No captures. pc_q holds.
  - When the fault entry is consumed (valid && ready), instr_valid_o <= 0 and fetch_fault_o <= 0.
  - FAULT is left only via redirect or reset.
- Redirect targets are not checked when accepted; a bad target faults on its first capture.
- fetch_count_o increments by 1 on every edge with instr_valid_o && instr_ready_i, including a fault entry and a cycle with a simultaneous redirect. It wraps from 32'hFFFF_FFFF to 0. Only reset clears it.

## Timing
- Fetch latency: 1 cycle. The first edge with rst_i=0 captures the word at RESET_PC; instr_valid_o=1 is visible after that edge.
- Throughput: 1 instruction/cycle while instr_ready_i=1.
- Redirect penalty: 1 bubble. Redirect on edge N gives instr_valid_o=0 after N; the target instruction is valid after N+1.
- Output stability: instr_o, instr_pc_o and fetch_fault_o do not change while instr_valid_o=1 && instr_ready_i=0, except on redirect or reset.
- Reset asserted mid-stream: all outputs take reset values after that edge, regardless of handshake or redirect.
- imem_addr_o changes only at clock edges. There is no combinational path from instr_ready_i or redirect_i to any output.

## Test plan
- Reset then straight-line run: memory holds 0x11,0x22,0x33 at PCs 0,4,8; ready=1 -> outputs (0,0x11), (4,0x22), (8,0x33) on consecutive cycles; fetch_count_o=3 after the third handshake.
- Backpressure: ready=0 for 3 cycles while holding (4,0x22) -> instr_o and instr_pc_o stable, imem_addr_o=8; ready=1 -> next entry (8,0x33).
- Redirect: redirect_i=1, redirect_pc_i=0x40 while (8,0x33) is valid with ready=1 -> valid=0 for one cycle, then (0x40, RAM[16]); count includes 0x33.
- Misaligned redirect to 0x42 -> valid entry with fetch_fault_o=1, instr_o=0, instr_pc_o=0x42. After consumption valid stays 0 for 5 idle cycles. Redirect to 0x0 resumes with (0, 0x11).
- Out-of-range fetch: run to PC 0xFFC then 0x1000 -> (0xFFC, RAM[1023]) normal, then a fault entry with instr_pc_o=0x1000.
- Reset mid-stall with valid=1 and ready=0 -> after the edge valid=0, count=0, imem_addr_o=RESET_PC; the next edge refetches RESET_PC.
